spatz_vrf_banked: RTL and testbench
===================================

Name: spatz_vrf_banked

Overview:
Parametrised banked vector register file for the Spatz VFU/LSU/slide units: NrBanks flop-based banks, each with one write port and NrReadPortsPerBank read ports. Per-bank-port arbitration (fixed-priority or round-robin) serves any number of requesters. Request/grant handshake on both sides; read data is registered (1-cycle latency). Replaces the hard-wired 4-bank, 5R/3W file with combinational reads.

Parameters:
NrBanks, 4, number of banks (power of 2, >=1)
NrRegs, 32, architectural vector registers
NrElemPerBank, 2, elements per register per bank (power of 2, >=1)
ElemWidth, 64, element width in bits (multiple of 8)
NrReadPorts, 5, read requesters
NrWritePorts, 3, write requesters
NrReadPortsPerBank, 3, physical read ports per bank
ArbMode, ArbRoundRobin, arbitration mode (ArbFixed | ArbRoundRobin)
AddrWidth, derived, clog2(NrRegs)+clog2(NrBanks)+clog2(NrElemPerBank); default 8

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
waddr_i  in  NrWritePorts x AddrWidth  write address {reg, bank, elem}, elem in LSBs
wdata_i  in  NrWritePorts x ElemWidth  write data
wbe_i  in  NrWritePorts x ElemWidth/8  byte enables
we_i  in  NrWritePorts  write request
wgnt_o  out  NrWritePorts  write granted this cycle (combinational)
raddr_i  in  NrReadPorts x AddrWidth  read address
re_i  in  NrReadPorts  read request
rgnt_o  out  NrReadPorts  read granted this cycle (combinational)
rdata_o  out  NrReadPorts x ElemWidth  read data, registered
rvalid_o  out  NrReadPorts  rdata_o valid, one cycle after grant

Behaviour:
- Address decode: elem = addr[clog2(NrElemPerBank)-1:0]; bank = next clog2(NrBanks) bits; reg = MSBs. A width-0 field is omitted.
- Write arbitration: per bank, all write requesters addressing that bank compete for its single write port. ArbFixed: lowest index wins. ArbRoundRobin: winner is the first requester at or after the pointer; the pointer moves to winner+1 (mod NrWritePorts) only when a grant is issued and holds otherwise. Each requester's grant is asserted for at most one bank.
- Write commit: the granted write updates the enabled bytes at the clock edge ending the grant cycle; bytes with wbe=0 are unchanged. A grant with wbe=0 is a legal no-op.
- Read arbitration: requester i competes only for bank read port (i mod NrReadPortsPerBank) of its target bank, with the same fixed/RR rules and an independent pointer per bank read port.
- Read data: on grant in cycle t, rdata_o[i]/rvalid_o[i] are valid in t+1. rvalid_o is a 1-cycle pulse per grant; back-to-back grants give back-to-back pulses. rdata_o holds its last value when rvalid_o=0.
- Read-during-write to the same element in one cycle: the read returns the old data (no bypass).
- Ungranted requesters must hold request, address and data stable until granted. No timeout.
- Reset (async assert, sync deassert is the integrator's job): memory = 0, rdata_o = 0, rvalid_o = 0, all RR pointers = 0. wgnt_o/rgnt_o are forced to 0 while rst_i = 1. Reset mid-operation drops in-flight read responses, and no write commits.
- Elaboration errors: NrReadPortsPerBank = 0; any non-power-of-2 bank/element count; ElemWidth % 8 != 0.

Decomposition:
- spatz_pkg: arb_mode_e {ArbFixed, ArbRoundRobin}; vreg_addr_t, vreg_data_t and vreg_be_t re-parametrised through AddrWidth and ElemWidth.
- Sub-module spatz_vrf_arb: N-input fixed/round-robin arbiter with pointer state, parametrised by N and mode. Instantiate one per bank write port and one per bank read port.
- Banks are flop arrays in an inner generate loop; no separate bank module.

Test Plan:
- Reset: pulse rst_i, then read addr 0x00 and 0xFF on ports 0..4 -> rgnt_o=1, and one cycle later rvalid_o=1 with rdata_o=0.
- Byte-enable write: port0 writes 0x09 (reg1, bank0, elem1), data 0x1122334455667788, wbe 0x0F -> wgnt_o[0]=1 same cycle; the next read of 0x09 returns 0x0000000055667788.
- Write conflict: we_i[0], we_i[1] both to bank 2, held. ArbRoundRobin -> grants 0 then 1 on consecutive cycles. ArbFixed -> port0 granted every cycle while it holds its request.
- Read port mapping: ports 0 and 3 read bank 1 -> one granted per cycle, the other next cycle. Ports 0 and 1 read bank 1 -> both granted same cycle, data identical if same address.
- Read-during-write: write 0xAA.. and read 0x12 in the same cycle -> the read returns the old value; a read next cycle returns 0xAA...
- Mid-op reset: grant a read, then assert rst_i before the next edge -> rvalid_o stays 0 and the RR pointer restarts at 0, so port0 wins first after reset.

Source files
------------

// File: rtl/spatz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spatz_pkg                                                        |
// | Brief   : Shared types and helpers for the Spatz banked vector reg file.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package spatz_pkg;

    typedef enum logic [0:0] {
        ArbFixed      = 1'b0,
        ArbRoundRobin = 1'b1
    } arb_mode_e;

    localparam int unsigned VREG_ADDR_WIDTH = 8;
    localparam int unsigned VREG_ELEM_WIDTH = 64;

    typedef logic [VREG_ADDR_WIDTH-1:0]   vreg_addr_t;
    typedef logic [VREG_ELEM_WIDTH-1:0]   vreg_data_t;
    typedef logic [VREG_ELEM_WIDTH/8-1:0] vreg_be_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned f_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit f_is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spatz_vrf_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spatz_vrf_arb                                                    |
// | Brief   : N-input fixed-priority / round-robin arbiter with pointer state. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spatz_vrf_arb
    import spatz_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter arb_mode_e   MODE = ArbRoundRobin
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned c_ptr_w = f_idx_width(N);

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_ptr_nxt;
    logic [c_ptr_w-1:0] w_start;
    logic [c_ptr_w-1:0] w_sel;
    logic               w_found;
    int unsigned        w_idx;

    // Scan from the pointer (or from 0 in fixed mode); first requester wins.
    always_comb begin
        gnt       = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        w_idx     = 0;
        w_sel     = '0;
        w_start   = (MODE == ArbRoundRobin) ? r_ptr : '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = (32'(w_start) + k) % N;
            w_sel = c_ptr_w'(w_idx);
            if (!w_found && req[w_sel]) begin
                gnt[w_sel] = 1'b1;
                w_found    = 1'b1;
                w_ptr_nxt  = c_ptr_w'((w_idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (MODE == ArbRoundRobin && w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spatz_vrf_banked.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spatz_vrf_banked                                                 |
// | Brief   : Banked flop VRF, per-bank-port arbitration, registered reads.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spatz_vrf_banked
    import spatz_pkg::*;
#(
    parameter int unsigned NR_BANKS               = 4,
    parameter int unsigned NR_REGS                = 32,
    parameter int unsigned NR_ELEM_PER_BANK       = 2,
    parameter int unsigned ELEM_WIDTH             = 64,
    parameter int unsigned NR_READ_PORTS          = 5,
    parameter int unsigned NR_WRITE_PORTS         = 3,
    parameter int unsigned NR_READ_PORTS_PER_BANK = 3,
    parameter arb_mode_e   ARB_MODE               = ArbRoundRobin,
    localparam int unsigned ELEM_BITS  = $clog2(NR_ELEM_PER_BANK),
    localparam int unsigned BANK_BITS  = $clog2(NR_BANKS),
    localparam int unsigned ADDR_WIDTH = $clog2(NR_REGS) + BANK_BITS + ELEM_BITS
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]     waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][ELEM_WIDTH-1:0]     wdata_i,
    input  logic [NR_WRITE_PORTS-1:0][ELEM_WIDTH/8-1:0]   wbe_i,
    input  logic [NR_WRITE_PORTS-1:0]                     we_i,
    output logic [NR_WRITE_PORTS-1:0]                     wgnt_o,
    input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]      raddr_i,
    input  logic [NR_READ_PORTS-1:0]                      re_i,
    output logic [NR_READ_PORTS-1:0]                      rgnt_o,
    output logic [NR_READ_PORTS-1:0][ELEM_WIDTH-1:0]      rdata_o,
    output logic [NR_READ_PORTS-1:0]                      rvalid_o
);

    localparam int unsigned c_bank_w = f_idx_width(NR_BANKS);
    localparam int unsigned c_depth  = NR_REGS * NR_ELEM_PER_BANK;
    localparam int unsigned c_row_w  = f_idx_width(c_depth);
    localparam int unsigned c_be_w   = ELEM_WIDTH / 8;

    if (NR_READ_PORTS_PER_BANK == 0) begin : g_err_rpb
        $error("spatz_vrf_banked: NR_READ_PORTS_PER_BANK must be >= 1");
    end
    if (!f_is_pow2(NR_BANKS) || !f_is_pow2(NR_ELEM_PER_BANK)) begin : g_err_pow2
        $error("spatz_vrf_banked: bank and element counts must be powers of 2");
    end
    if (ELEM_WIDTH % 8 != 0) begin : g_err_width
        $error("spatz_vrf_banked: ELEM_WIDTH must be a multiple of 8");
    end

    function automatic logic [c_bank_w-1:0] f_bank(input logic [ADDR_WIDTH-1:0] a);
        return c_bank_w'((32'(a) >> ELEM_BITS) % NR_BANKS);
    endfunction

    // Row inside a bank is {reg, elem}; the bank field is squeezed out.
    function automatic logic [c_row_w-1:0] f_row(input logic [ADDR_WIDTH-1:0] a);
        return c_row_w'((32'(a) >> (ELEM_BITS + BANK_BITS)) * NR_ELEM_PER_BANK
                        + (32'(a) % NR_ELEM_PER_BANK));
    endfunction

    logic [ELEM_WIDTH-1:0]     r_mem [NR_BANKS][c_depth];
    logic [NR_WRITE_PORTS-1:0] w_wreq [NR_BANKS];
    logic [NR_WRITE_PORTS-1:0] w_wgnt_bank [NR_BANKS];
    logic                      w_bank_we [NR_BANKS];
    logic [c_row_w-1:0]        w_bank_row [NR_BANKS];
    logic [ELEM_WIDTH-1:0]     w_bank_data [NR_BANKS];
    logic [c_be_w-1:0]         w_bank_be [NR_BANKS];

    logic [NR_READ_PORTS-1:0]  w_rreq [NR_BANKS][NR_READ_PORTS_PER_BANK];
    logic [NR_READ_PORTS-1:0]  w_rgnt_bp [NR_BANKS][NR_READ_PORTS_PER_BANK];
    logic [NR_READ_PORTS-1:0]  w_rgnt;
    logic [NR_WRITE_PORTS-1:0] w_wgnt;

    logic [NR_READ_PORTS-1:0][ELEM_WIDTH-1:0] r_rdata;
    logic [NR_READ_PORTS-1:0]                 r_rvalid;

    // Requests are masked during reset so no grant, commit or pointer move occurs.
    always_comb begin
        for (int b = 0; b < NR_BANKS; b++) begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                w_wreq[b][j] = we_i[j] && !rst_i && (f_bank(waddr_i[j]) == c_bank_w'(b));
            end
            for (int p = 0; p < NR_READ_PORTS_PER_BANK; p++) begin
                for (int i = 0; i < NR_READ_PORTS; i++) begin
                    w_rreq[b][p][i] = re_i[i] && !rst_i
                                      && ((i % NR_READ_PORTS_PER_BANK) == p)
                                      && (f_bank(raddr_i[i]) == c_bank_w'(b));
                end
            end
        end
    end

    for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
        spatz_vrf_arb #(
            .N    (NR_WRITE_PORTS),
            .MODE (ARB_MODE)
        ) u_warb (
            .clk (clk_i),
            .rst (rst_i),
            .req (w_wreq[b]),
            .gnt (w_wgnt_bank[b])
        );

        for (genvar p = 0; p < NR_READ_PORTS_PER_BANK; p++) begin : g_rport
            spatz_vrf_arb #(
                .N    (NR_READ_PORTS),
                .MODE (ARB_MODE)
            ) u_rarb (
                .clk (clk_i),
                .rst (rst_i),
                .req (w_rreq[b][p]),
                .gnt (w_rgnt_bp[b][p])
            );
        end
    end

    always_comb begin
        w_wgnt = '0;
        w_rgnt = '0;
        for (int b = 0; b < NR_BANKS; b++) begin
            w_bank_we[b]   = 1'b0;
            w_bank_row[b]  = '0;
            w_bank_data[b] = '0;
            w_bank_be[b]   = '0;
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (w_wgnt_bank[b][j]) begin
                    w_bank_we[b]   = 1'b1;
                    w_bank_row[b]  = f_row(waddr_i[j]);
                    w_bank_data[b] = wdata_i[j];
                    w_bank_be[b]   = wbe_i[j];
                end
            end
            w_wgnt = w_wgnt | w_wgnt_bank[b];
            for (int i = 0; i < NR_READ_PORTS; i++) begin
                w_rgnt[i] = w_rgnt[i] | w_rgnt_bp[b][i % NR_READ_PORTS_PER_BANK][i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NR_BANKS; b++) begin
                for (int r = 0; r < c_depth; r++) begin
                    r_mem[b][r] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NR_BANKS; b++) begin
                if (w_bank_we[b]) begin
                    for (int k = 0; k < c_be_w; k++) begin
                        if (w_bank_be[b][k]) begin
                            r_mem[b][w_bank_row[b]][8*k +: 8] <= w_bank_data[b][8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Reads sample the pre-write contents, so same-cycle writes are not bypassed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rgnt;
            for (int i = 0; i < NR_READ_PORTS; i++) begin
                if (w_rgnt[i]) begin
                    r_rdata[i] <= r_mem[f_bank(raddr_i[i])][f_row(raddr_i[i])];
                end
            end
        end
    end

    assign wgnt_o   = w_wgnt;
    assign rgnt_o   = w_rgnt;
    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_spatz_vrf_banked.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spatz_vrf_banked                                              |
// | Brief   : Directed table-driven bench for spatz_vrf_banked (RR and fixed). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spatz_vrf_banked;
    import spatz_pkg::*;

    typedef struct {
        logic [2:0]        we;
        logic [2:0][7:0]   waddr;
        logic [2:0][63:0]  wdata;
        logic [2:0][7:0]   wbe;
        logic [4:0]        re;
        logic [4:0][7:0]   raddr;
        logic [2:0]        exp_wgnt;
        logic [2:0]        exp_wgnt_fx;
        logic [4:0]        exp_rgnt;
        logic [4:0]        exp_rvalid;
        logic [4:0][63:0]  exp_rdata;
    } vec_t;

    logic             clk;
    logic             rst_i;
    logic [2:0][7:0]  waddr;
    logic [2:0][63:0] wdata;
    logic [2:0][7:0]  wbe;
    logic [2:0]       we;
    logic [4:0][7:0]  raddr;
    logic [4:0]       re;

    logic [2:0]       wgnt_rr, wgnt_fx;
    logic [4:0]       rgnt_rr, rgnt_fx;
    logic [4:0][63:0] rdata_rr, rdata_fx;
    logic [4:0]       rvalid_rr, rvalid_fx;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[$];
    vec_t v;

    spatz_vrf_banked #(.ARB_MODE(ArbRoundRobin)) u_dut_rr (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .wbe_i    (wbe),
        .we_i     (we),
        .wgnt_o   (wgnt_rr),
        .raddr_i  (raddr),
        .re_i     (re),
        .rgnt_o   (rgnt_rr),
        .rdata_o  (rdata_rr),
        .rvalid_o (rvalid_rr)
    );

    spatz_vrf_banked #(.ARB_MODE(ArbFixed)) u_dut_fx (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .wbe_i    (wbe),
        .we_i     (we),
        .wgnt_o   (wgnt_fx),
        .raddr_i  (raddr),
        .re_i     (re),
        .rgnt_o   (rgnt_fx),
        .rdata_o  (rdata_fx),
        .rvalid_o (rvalid_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input int p, input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
        v.we[p] = 1'b1; v.waddr[p] = a; v.wdata[p] = d; v.wbe[p] = be;
    endtask

    task automatic rd(input int p, input logic [7:0] a);
        v.re[p] = 1'b1; v.raddr[p] = a;
    endtask

    task automatic er(input int p, input logic [63:0] d);
        v.exp_rvalid[p] = 1'b1; v.exp_rdata[p] = d;
    endtask

    task automatic gnt(input logic [2:0] w, input logic [2:0] wfx, input logic [4:0] r);
        v.exp_wgnt = w; v.exp_wgnt_fx = wfx; v.exp_rgnt = r;
        tbl.push_back(v);
        v = '{default: '0};
    endtask

    localparam logic [63:0] c_old = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] c_aa  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] c_d0  = 64'hD0D0_D0D0_0000_0004;
    localparam logic [63:0] c_d1  = 64'hD1D1_D1D1_0000_0005;

    initial begin
        v = '{default: '0};
        // 0: reset contents seen on every read port
        rd(0, 8'h00); rd(1, 8'hFF); rd(2, 8'h00); rd(3, 8'hFF); rd(4, 8'h00);
        for (int i = 0; i < 5; i++) er(i, 64'h0);
        gnt(3'b000, 3'b000, 5'b11111);
        // 1-2: partial byte-enable write then read back
        wr(0, 8'h09, 64'h1122_3344_5566_7788, 8'h0F);
        gnt(3'b001, 3'b001, 5'b00000);
        rd(0, 8'h09); er(0, 64'h0000_0000_5566_7788);
        gnt(3'b000, 3'b000, 5'b00001);
        // 3-5: read-during-write returns old data, next read sees new
        wr(0, 8'h12, c_old, 8'hFF);
        gnt(3'b001, 3'b001, 5'b00000);
        wr(1, 8'h12, c_aa, 8'hFF); rd(2, 8'h12); er(2, c_old);
        gnt(3'b010, 3'b010, 5'b00100);
        rd(2, 8'h12); er(2, c_aa);
        gnt(3'b000, 3'b000, 5'b00100);
        // 6: ports 0 and 1 use different bank read ports
        rd(0, 8'h12); rd(1, 8'h12); er(0, c_aa); er(1, c_aa);
        gnt(3'b000, 3'b000, 5'b00011);
        // 7-8: ports 0 and 3 share bank1 read port 0; pointer sits at 1
        rd(0, 8'h12); rd(3, 8'h12); er(3, c_aa);
        gnt(3'b000, 3'b000, 5'b01000);
        rd(0, 8'h12); er(0, c_aa);
        gnt(3'b000, 3'b000, 5'b00001);
        // 9-11: held write conflict on bank 2
        wr(0, 8'h04, c_d0, 8'hFF); wr(1, 8'h05, c_d1, 8'hFF);
        gnt(3'b001, 3'b001, 5'b00000);
        wr(0, 8'h04, c_d0, 8'hFF); wr(1, 8'h05, c_d1, 8'hFF);
        gnt(3'b010, 3'b001, 5'b00000);
        wr(0, 8'h04, c_d0, 8'hFF); wr(1, 8'h05, c_d1, 8'hFF);
        gnt(3'b001, 3'b001, 5'b00000);
        // 12: read back both conflict targets
        rd(0, 8'h04); rd(1, 8'h05); er(0, c_d0); er(1, c_d1);
        gnt(3'b000, 3'b000, 5'b00011);

        rst_i = 1'b1;
        we = 3'b111; waddr = '0; wdata = '1; wbe = '1;
        re = 5'b11111; raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset wgnt", 64'(wgnt_rr), 64'h0);
        check("reset rgnt", 64'(rgnt_rr), 64'h0);
        check("reset rgnt fixed", 64'(rgnt_fx), 64'h0);
        check("reset rvalid", 64'(rvalid_rr), 64'h0);
        check("reset rvalid fixed", 64'(rvalid_fx), 64'h0);
        check("reset rdata0", rdata_rr[0], 64'h0);
        check("reset rdata4", rdata_rr[4], 64'h0);
        we = '0; re = '0; wbe = '0; wdata = '0;
        rst_i = 1'b0;

        for (int n = 0; n < tbl.size(); n++) begin
            we = tbl[n].we; waddr = tbl[n].waddr; wdata = tbl[n].wdata; wbe = tbl[n].wbe;
            re = tbl[n].re; raddr = tbl[n].raddr;
            #1;
            check($sformatf("row%0d wgnt", n), 64'(wgnt_rr), 64'(tbl[n].exp_wgnt));
            check($sformatf("row%0d wgnt fixed", n), 64'(wgnt_fx), 64'(tbl[n].exp_wgnt_fx));
            check($sformatf("row%0d rgnt", n), 64'(rgnt_rr), 64'(tbl[n].exp_rgnt));
            @(posedge clk);
            #1;
            check($sformatf("row%0d rvalid", n), 64'(rvalid_rr), 64'(tbl[n].exp_rvalid));
            for (int i = 0; i < 5; i++) begin
                if (tbl[n].exp_rvalid[i])
                    check($sformatf("row%0d rdata%0d", n, i), rdata_rr[i], tbl[n].exp_rdata[i]);
            end
        end

        // Idle cycle: rvalid drops, rdata holds
        we = '0; re = '0;
        @(posedge clk);
        #1;
        check("idle rvalid", 64'(rvalid_rr), 64'h0);
        check("hold rdata0", rdata_rr[0], c_d0);
        check("hold rdata1", rdata_rr[1], c_d1);

        // Reset between grant and response edge
        re = 5'b01001; raddr[0] = 8'h12; raddr[3] = 8'h12;
        #1;
        check("pre-reset rgnt", 64'(rgnt_rr), 64'h08);
        #2;
        rst_i = 1'b1;
        #1;
        check("in-reset rgnt", 64'(rgnt_rr), 64'h0);
        @(posedge clk);
        #1;
        check("dropped rvalid", 64'(rvalid_rr), 64'h0);
        check("reset rdata3", rdata_rr[3], 64'h0);
        rst_i = 1'b0;
        #1;
        check("post-reset rgnt", 64'(rgnt_rr), 64'h01);
        @(posedge clk);
        #1;
        check("post-reset rvalid", 64'(rvalid_rr), 64'h01);
        check("post-reset rdata0", rdata_rr[0], 64'h0);
        re = '0;
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
